wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage and architectural register file of the 8-bit pipeline.
//  Consumes the MEM/WB pipeline-register outputs and selects memory or ALU data.
//  Commits the selected value to a 32-entry register file and serves two read ports to decode.
//  Also keeps a retired-write counter for debug and performance monitoring.
// PARAMETERS
//  DATA_W   8   register and data width
//  ADDR_W   5   register address width; NREGS = 2**ADDR_W = 32
//  CNT_W    16  width of the retired-write counter
// PORTS
//  clk          in   1       rising-edge clock, sole clock domain
//  reset        in   1       synchronous, active-low reset (0 at posedge = reset)
//  readdata_in  in   DATA_W  load data from MEM/WB
//  resultalu_in in   DATA_W  ALU result from MEM/WB
//  rd_in        in   ADDR_W  destination register from MEM/WB
//  memtoreg_in  in   1       1 = write readdata_in, 0 = write resultalu_in
//  regwrite_in  in   1       1 = commit the write this cycle
//  rs1_addr     in   ADDR_W  read port 1 address
//  rs2_addr     in   ADDR_W  read port 2 address
//  rs1_data     out  DATA_W  read port 1 data (combinational)
//  rs2_data     out  DATA_W  read port 2 data (combinational)
//  wb_data      out  DATA_W  combinational write-back mux result
//  wb_last_rd   out  ADDR_W  registered rd of the last committed write
//  wb_last_data out  DATA_W  registered data of the last committed write
//  wb_count     out  CNT_W   registered count of committed writes
// BEHAVIOUR
//  - wb_data = memtoreg_in ? readdata_in : resultalu_in. Pure mux, no clock.
//  - Commit condition: commit = regwrite_in & (rd_in != 0) & reset.
//  - On each posedge with commit true:
//      regs[rd_in]  <= wb_data
//      wb_last_rd   <= rd_in
//      wb_last_data <= wb_data
//      wb_count     <= wb_count + 1
//  - Without a commit, all state holds.
//  - r0 is hardwired to zero:
//      writes to rd_in == 0 are discarded and wb_count is not incremented;
//      reads of address 0 always return 0.
//  - Reads are combinational from the array, with the bypass rule in CONFIGURATION.
//  - Both read ports are independent and may use the same address.
//  - Reset (reset == 0 at posedge):
//      all 32 registers, wb_last_rd, wb_last_data and wb_count go to 0 in that cycle;
//      a write presented in the same cycle is dropped.
//      After the reset cycle, rs*_data read 0 for every address.
//  - Reset mid-stream: pending MEM/WB inputs are ignored while reset is low.
//      Normal commits resume on the first posedge with reset == 1.
//  - Counter arithmetic: wb_count is unsigned and wraps from 2**CNT_W-1 to 0 with no flag.
//  - Latency: a written value is visible on the read ports the cycle after commit.
//      With bypass enabled, it is visible in the same cycle.
//  - Inputs are not X-checked; an X on regwrite_in is an integration error.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    if commit is true and rsN_addr == rd_in, then rsN_data = wb_data in the same cycle
//    (write-through, so the decode stage sees the result without a stall).
//  WB_BYPASS_EN undefined:
//    rsN_data always reflects the array contents.
//    Decode must stall one cycle on a same-cycle read-after-write hazard.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles with regwrite_in=1 and rd_in=3
//      -> all rs*_data = 0 for addresses 0..31; wb_count = 0; wb_last_* = 0.
//  2 Mux and commit: rd_in=5, memtoreg_in=1, readdata_in=8'hA5, resultalu_in=8'h3C, regwrite_in=1
//      -> next cycle rs1_addr=5 gives 8'hA5; wb_last_rd=5; wb_count=1.
//      Repeat with memtoreg_in=0 -> 8'h3C; wb_count=2.
//  3 r0: write 8'hFF to rd_in=0 -> rs1_data(0) = 0; wb_count unchanged; wb_last_* unchanged.
//  4 Bypass: reg 7 = 8'h11; same cycle write 8'h22 to rd_in=7 with rs1_addr=rs2_addr=7
//      -> WB_BYPASS_EN: both ports read 8'h22 that cycle.
//      -> without the macro: 8'h11 that cycle, 8'h22 the next.
//  5 Wrap: drive 65536 commits to rd_in=1
//      -> wb_count reads 16'hFFFF after 65535 and 0 after 65536.
//  6 Mid-stream reset: after writes to r1..r4, assert reset=0 for 1 cycle during a write to r9
//      -> r1..r4 and r9 read 0; wb_count = 0; the next write commits normally.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 32 x 8-bit architectural register file with two
// combinational read ports, last-write capture and a wrapping retired-write counter.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-through on the read ports).
module wb_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] readdata_in,
  input  logic [DATA_W-1:0] resultalu_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_last_rd,
  output logic [DATA_W-1:0] wb_last_data,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [ADDR_W-1:0] wb_last_rd_q, wb_last_rd_d;
  logic [DATA_W-1:0] wb_last_data_q, wb_last_data_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;
  logic              commit;

  assign wb_data = memtoreg_in ? readdata_in : resultalu_in;

  // Writes to r0 never commit; reset low also blocks the write presented with it.
  assign commit = regwrite_in & (rd_in != '0) & reset;

  // Next-state: commit the selected value and advance the retired-write counter.
  always_comb begin
    regs_d         = regs_q;
    wb_last_rd_d   = wb_last_rd_q;
    wb_last_data_d = wb_last_data_q;
    wb_count_d     = wb_count_q;
    if (commit) begin
      regs_d[rd_in]  = wb_data;
      wb_last_rd_d   = rd_in;
      wb_last_data_d = wb_data;
      wb_count_d     = wb_count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset clearing the whole array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_last_rd_q   <= '0;
      wb_last_data_q <= '0;
      wb_count_q     <= '0;
    end else begin
      regs_q         <= regs_d;
      wb_last_rd_q   <= wb_last_rd_d;
      wb_last_data_q <= wb_last_data_d;
      wb_count_q     <= wb_count_d;
    end
  end

  // Read ports: r0 reads zero; optional write-through of the value being committed.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
    if (commit && (rs1_addr == rd_in)) rs1_data = wb_data;
    if (commit && (rs2_addr == rd_in)) rs2_data = wb_data;
`else
`endif
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

  assign wb_last_rd   = wb_last_rd_q;
  assign wb_last_data = wb_last_data_q;
  assign wb_count     = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, corner sequences,
// randomized run against an array-based reference model, counter wrap.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  readdata_in, resultalu_in;
  logic [4:0]  rd_in;
  logic        memtoreg_in, regwrite_in;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [7:0]  rs1_data, rs2_data, wb_data;
  logic [4:0]  wb_last_rd;
  logic [7:0]  wb_last_data;
  logic [15:0] wb_count;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .readdata_in(readdata_in), .resultalu_in(resultalu_in),
    .rd_in(rd_in), .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
    .wb_last_rd(wb_last_rd), .wb_last_data(wb_last_data), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, we, m2r;
    logic [4:0]  rd;
    logic [7:0]  rdat, alu;
    logic [4:0]  a1, a2;
    logic [7:0]  e_wb, e_r1, e_r2;
    logic [15:0] e_cnt;
    logic [4:0]  e_lrd;
    logic [7:0]  e_ld;
  } vec_t;

  vec_t vecs [12];

  // reference model state
  logic [7:0]  mregs [32];
  logic [15:0] mcount;
  logic [4:0]  mlast_rd;
  logic [7:0]  mlast_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, we, m2r, input logic [4:0] rd,
                       input logic [7:0] rdat, alu, input logic [4:0] a1, a2);
    reset = rst; regwrite_in = we; memtoreg_in = m2r; rd_in = rd;
    readdata_in = rdat; resultalu_in = alu; rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.rst, v.we, v.m2r, v.rd, v.rdat, v.alu, v.a1, v.a2);
    @(negedge clk);
    check($sformatf("vec%0d wb_data", idx), 32'(wb_data), 32'(v.e_wb));
    check($sformatf("vec%0d rs1_data", idx), 32'(rs1_data), 32'(v.e_r1));
    check($sformatf("vec%0d rs2_data", idx), 32'(rs2_data), 32'(v.e_r2));
    @(posedge clk); #1;
    check($sformatf("vec%0d wb_count", idx), 32'(wb_count), 32'(v.e_cnt));
    check($sformatf("vec%0d wb_last_rd", idx), 32'(wb_last_rd), 32'(v.e_lrd));
    check($sformatf("vec%0d wb_last_data", idx), 32'(wb_last_data), 32'(v.e_ld));
  endtask

  function automatic logic [7:0] model_read(input logic [4:0] a, input bit commit,
                                            input logic [4:0] rd, input logic [7:0] wv);
    if (a == 0) return 8'h00;
    if (BYP && commit && a == rd) return wv;
    return mregs[a];
  endfunction

  // One cycle checked against the reference model.
  task automatic mstep(input logic rst, we, m2r, input logic [4:0] rd,
                       input logic [7:0] rdat, alu, input logic [4:0] a1, a2);
    logic [7:0] ewb;
    bit commit;
    drive(rst, we, m2r, rd, rdat, alu, a1, a2);
    ewb = m2r ? rdat : alu;
    commit = we && (rd != 0) && rst;
    @(negedge clk);
    check("model wb_data", 32'(wb_data), 32'(ewb));
    check("model rs1_data", 32'(rs1_data), 32'(model_read(a1, commit, rd, ewb)));
    check("model rs2_data", 32'(rs2_data), 32'(model_read(a2, commit, rd, ewb)));
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
      mcount = 0; mlast_rd = 0; mlast_data = 0;
    end else if (commit) begin
      mregs[rd] = ewb;
      mlast_rd = rd;
      mlast_data = ewb;
      mcount = 16'((32'(mcount) + 1) % 65536);
    end
    #1;
    check("model wb_count", 32'(wb_count), 32'(mcount));
    check("model wb_last_rd", 32'(wb_last_rd), 32'(mlast_rd));
    check("model wb_last_data", 32'(wb_last_data), 32'(mlast_data));
  endtask

  initial begin
    // directed table (starts from a freshly reset file)
    vecs[0]  = '{1,1,1, 5, 8'hA5,8'h3C, 5,0, 8'hA5, BYP ? 8'hA5 : 8'h00, 8'h00, 1, 5, 8'hA5};
    vecs[1]  = '{1,1,0, 5, 8'hA5,8'h3C, 5,5, 8'h3C, BYP ? 8'h3C : 8'hA5, BYP ? 8'h3C : 8'hA5, 2, 5, 8'h3C};
    vecs[2]  = '{1,0,0, 6, 8'h00,8'h44, 5,6, 8'h44, 8'h3C, 8'h00, 2, 5, 8'h3C};
    vecs[3]  = '{1,1,0, 0, 8'h00,8'hFF, 0,5, 8'hFF, 8'h00, 8'h3C, 2, 5, 8'h3C};
    vecs[4]  = '{1,0,0, 0, 8'h00,8'h12, 0,0, 8'h12, 8'h00, 8'h00, 2, 5, 8'h3C};
    vecs[5]  = '{1,1,1, 7, 8'h11,8'h99, 7,7, 8'h11, BYP ? 8'h11 : 8'h00, BYP ? 8'h11 : 8'h00, 3, 7, 8'h11};
    vecs[6]  = '{1,1,1, 7, 8'h22,8'h99, 7,7, 8'h22, BYP ? 8'h22 : 8'h11, BYP ? 8'h22 : 8'h11, 4, 7, 8'h22};
    vecs[7]  = '{1,0,1, 7, 8'h33,8'h00, 7,7, 8'h33, 8'h22, 8'h22, 4, 7, 8'h22};
    vecs[8]  = '{0,1,1, 9, 8'h55,8'h00, 7,5, 8'h55, 8'h22, 8'h3C, 0, 0, 8'h00};
    vecs[9]  = '{1,0,0, 0, 8'h00,8'h5A, 7,5, 8'h5A, 8'h00, 8'h00, 0, 0, 8'h00};
    vecs[10] = '{1,1,0, 9, 8'h00,8'h66, 9,0, 8'h66, BYP ? 8'h66 : 8'h00, 8'h00, 1, 9, 8'h66};
    vecs[11] = '{1,0,0, 9, 8'h00,8'h01, 9,9, 8'h01, 8'h66, 8'h66, 1, 9, 8'h66};

    // reset held two cycles with a write to r3 pending
    drive(0, 1, 1, 3, 8'h77, 8'h88, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    check("reset wb_count", 32'(wb_count), 32'h0);
    check("reset wb_last_rd", 32'(wb_last_rd), 32'h0);
    check("reset wb_last_data", 32'(wb_last_data), 32'h0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      @(negedge clk);
      check($sformatf("reset rs1[%0d]", a), 32'(rs1_data), 32'h0);
      check($sformatf("reset rs2[%0d]", 31 - a), 32'(rs2_data), 32'h0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // mid-stream reset: r1..r4 written, reset during write to r9
    mstep(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int r = 1; r <= 4; r++) mstep(1, 1, 0, 5'(r), 8'h00, 8'(8'h10 + r), 5'(r), 0);
    mstep(0, 1, 1, 9, 8'hC9, 8'h00, 1, 2);
    drive(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int r = 1; r <= 5; r++) begin
      rs1_addr = (r == 5) ? 5'd9 : 5'(r);
      rs2_addr = (r == 5) ? 5'd9 : 5'(r);
      @(negedge clk);
      check($sformatf("midreset rs1[%0d]", rs1_addr), 32'(rs1_data), 32'h0);
      check($sformatf("midreset rs2[%0d]", rs2_addr), 32'(rs2_data), 32'h0);
    end
    check("midreset wb_count", 32'(wb_count), 32'h0);
    @(posedge clk); #1;
    drive(1, 1, 1, 9, 8'hE4, 8'h00, 9, 0);
    @(posedge clk); #1;
    regwrite_in = 0;
    @(negedge clk);
    check("post-reset write r9", 32'(rs1_data), 32'hE4);
    check("post-reset wb_count", 32'(wb_count), 32'h1);
    @(posedge clk); #1;

    // randomized run against the model
    mstep(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a1, a2, rd;
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 31));
      mstep(($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom), rd,
            8'($urandom), 8'($urandom), a1, a2);
    end

    // counter wrap: 65536 commits to r1
    mstep(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    drive(1, 1, 0, 1, 8'h00, 8'h00, 1, 0);
    for (int i = 0; i < 65535; i++) begin
      resultalu_in = 8'(i);
      @(posedge clk);
    end
    #1;
    check("wrap count at 65535", 32'(wb_count), 32'hFFFF);
    resultalu_in = 8'hAB;
    @(posedge clk); #1;
    check("wrap count at 65536", 32'(wb_count), 32'h0);
    check("wrap last_data", 32'(wb_last_data), 32'hAB);
    regwrite_in = 0;
    @(negedge clk);
    check("wrap r1 value", 32'(rs1_data), 32'hAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
